// File: rtl/uart_prog_sender.sv
// UART program-load sender: 8N1 serializer plus a sequencer that emits 0x55, an idle gap,
// 0xAA, then len streamed program bytes; a pass-through byte path is available when idle.
module uart_prog_sender #(
    parameter int unsigned CLOCK_HZ = 27000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned GAP_US   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic        wr,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        tx
);

    localparam int unsigned BIT_CYC = CLOCK_HZ / BAUD;
    localparam int unsigned GAP_CYC =
        int'((longint'(CLOCK_HZ) * longint'(GAP_US)) / longint'(1000000));
    localparam int unsigned BIT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE, SEND55, GAP, SENDAA, STREAM, FIN
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       bit_q, bit_d;
    logic [BIT_W-1:0] cyc_q, cyc_d;
    logic             active_q, active_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [15:0]      cnt_q, cnt_d;

    logic       ser_idle, ser_last, accept, wr_go, gap_end, src_take;
    logic       load;
    logic [7:0] load_byte;

    assign ser_idle = !active_q;
    assign ser_last = active_q && (bit_q == 4'd9) && (cyc_q == BIT_W'(BIT_CYC - 1));
    assign accept   = (state_q == IDLE) && ser_idle && start;
    // start wins over wr in the same cycle; the wr byte is dropped
    assign wr_go    = (state_q == IDLE) && ser_idle && wr && !start;
    assign gap_end  = (state_q == GAP) && (gap_q == GAP_W'(GAP_CYC - 1));
    assign src_take = src_ready && src_valid;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)   state_d = SEND55;
            SEND55:  if (ser_last) state_d = GAP;
            GAP:     if (gap_end)  state_d = SENDAA;
            SENDAA:  if (ser_last) state_d = (cnt_q == 16'd0) ? FIN : STREAM;
            STREAM:  if (ser_last && cnt_q == 16'd0) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == FIN);
        tx_ready  = (state_q == IDLE) && ser_idle;
        src_ready = (state_q == STREAM) && ser_idle && (cnt_q != 16'd0);
        load      = 1'b0;
        load_byte = '0;
        if (accept) begin
            load      = 1'b1;
            load_byte = 8'h55;
        end else if (wr_go) begin
            load      = 1'b1;
            load_byte = tx_data;
        end else if (gap_end) begin
            load      = 1'b1;
            load_byte = 8'hAA;
        end else if (src_take) begin
            load      = 1'b1;
            load_byte = src_data;
        end
    end

    always_comb begin
        shift_d  = shift_q;
        bit_d    = bit_q;
        cyc_d    = cyc_q;
        active_d = active_q;
        // ones shift in behind the frame, so tx rests high without extra muxing
        if (load) begin
            shift_d  = {1'b1, load_byte, 1'b0};
            bit_d    = '0;
            cyc_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cyc_q == BIT_W'(BIT_CYC - 1)) begin
                cyc_d   = '0;
                shift_d = {1'b1, shift_q[9:1]};
                bit_d   = bit_q + 4'd1;
                if (bit_q == 4'd9) active_d = 1'b0;
            end else begin
                cyc_d = cyc_q + BIT_W'(1);
            end
        end
        gap_d = ((state_q == GAP) && !gap_end) ? gap_q + GAP_W'(1) : '0;
        cnt_d = cnt_q;
        if (accept)        cnt_d = len;
        else if (src_take) cnt_d = cnt_q - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '1;
            bit_q    <= '0;
            cyc_q    <= '0;
            active_q <= 1'b0;
            gap_q    <= '0;
            cnt_q    <= '0;
        end else begin
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            cyc_q    <= cyc_d;
            active_q <= active_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tx = shift_q[0];

endmodule

// File: tb/tb_uart_prog_sender.sv
// Directed bench for uart_prog_sender at BIT_CYC=10, GAP_CYC=1152.
module tb_uart_prog_sender;

    logic        clk = 1'b0;
    logic        rst, start, wr, src_valid;
    logic [15:0] len;
    logic [7:0]  src_data, tx_data;
    logic        busy, done, src_ready, tx_ready, tx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int srdy_cnt = 0;

    uart_prog_sender #(.CLOCK_HZ(1152000), .BAUD(115200), .GAP_US(1000)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .wr(wr), .tx_data(tx_data), .tx_ready(tx_ready), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (src_valid === 1'b1 && src_ready === 1'b1) hs_cnt = hs_cnt + 1;
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (src_ready === 1'b1) srdy_cnt = srdy_cnt + 1;
    end

    // Waits (bounded) for a start bit, then samples each bit mid-cell; ok=0 on timeout or framing error.
    task automatic capture_frame(output logic [7:0] data, output int start_cyc, output bit ok);
        int n;
        ok = 1'b0;
        data = '0;
        start_cyc = 0;
        n = 0;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) return;
        start_cyc = cyc;
        repeat (5) @(negedge clk);
        if (tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            data[i] = tx;
        end
        repeat (10) @(negedge clk);
        if (tx !== 1'b1) return;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (src_ready !== 1'b0) begin failures++; $display("FAIL reset_src_ready got=%b exp=0", src_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    endtask

    task automatic test_wr_passthrough();
        logic [9:0] exp_bits;
        int bit_err[10];
        int rdy_bad, busy_bad;
        exp_bits = {1'b1, 8'h61, 1'b0};
        rdy_bad = 0;
        busy_bad = 0;
        for (int k = 0; k < 10; k++) bit_err[k] = 0;
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL wr_ready_before got=%b exp=1", tx_ready); end
        wr = 1'b1;
        tx_data = 8'h61;
        @(negedge clk);
        wr = 1'b0;
        tx_data = 8'h00;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 10; c++) begin
                if (tx !== exp_bits[k]) bit_err[k]++;
                if (tx_ready !== 1'b0) rdy_bad++;
                if (busy !== 1'b0) busy_bad++;
                @(negedge clk);
            end
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bit_err[k] != 0) begin
                failures++;
                $display("FAIL wr_bit%0d wrong_cycles=%0d exp_level=%b", k, bit_err[k], exp_bits[k]);
            end
        end
        checks++; if (rdy_bad != 0) begin failures++; $display("FAIL wr_tx_ready_low high_cycles=%0d exp=0", rdy_bad); end
        checks++; if (busy_bad != 0) begin failures++; $display("FAIL wr_busy busy_cycles=%0d exp=0", busy_bad); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL wr_ready_after got=%b exp=1", tx_ready); end
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL wr_tx_idle got=%b exp=1", tx); end
    endtask

    task automatic test_sequence();
        logic [7:0] d;
        int s55, saa, s, hs0, dn0, n;
        bit ok;
        hs0 = hs_cnt;
        dn0 = done_cnt;
        start = 1'b1;
        len = 16'd2;
        @(negedge clk);
        start = 1'b0;
        len = 16'hFFFF;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL seq_busy got=%b exp=1", busy); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL seq_tx_ready got=%b exp=0", tx_ready); end
        capture_frame(d, s55, ok);
        checks++; if (!ok || d !== 8'h55) begin failures++; $display("FAIL seq_frame55 got=%h ok=%b exp=55", d, ok); end
        capture_frame(d, saa, ok);
        checks++; if (!ok || d !== 8'hAA) begin failures++; $display("FAIL seq_frameAA got=%h ok=%b exp=aa", d, ok); end
        checks++; if (saa - s55 - 100 != 1152) begin failures++; $display("FAIL seq_gap got=%0d exp=1152", saa - s55 - 100); end
        src_valid = 1'b1;
        src_data = 8'h12;
        capture_frame(d, s, ok);
        checks++; if (!ok || d !== 8'h12) begin failures++; $display("FAIL seq_frame12 got=%h ok=%b exp=12", d, ok); end
        src_data = 8'h34;
        capture_frame(d, s, ok);
        checks++; if (!ok || d !== 8'h34) begin failures++; $display("FAIL seq_frame34 got=%h ok=%b exp=34", d, ok); end
        src_valid = 1'b0;
        src_data = 8'h00;
        n = 0;
        while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL seq_done_timeout got=%b exp=1", done); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL seq_busy_after got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL seq_done_pulse got=%b exp=0", done); end
        checks++; if (hs_cnt - hs0 != 2) begin failures++; $display("FAIL seq_handshakes got=%0d exp=2", hs_cnt - hs0); end
        checks++; if (done_cnt - dn0 != 1) begin failures++; $display("FAIL seq_done_count got=%0d exp=1", done_cnt - dn0); end
    endtask

    task automatic test_len_zero();
        logic [7:0] d;
        int s, sr0, dn0, n;
        bit ok;
        sr0 = srdy_cnt;
        dn0 = done_cnt;
        start = 1'b1;
        len = 16'd0;
        @(negedge clk);
        start = 1'b0;
        capture_frame(d, s, ok);
        checks++; if (!ok || d !== 8'h55) begin failures++; $display("FAIL len0_frame55 got=%h ok=%b exp=55", d, ok); end
        capture_frame(d, s, ok);
        checks++; if (!ok || d !== 8'hAA) begin failures++; $display("FAIL len0_frameAA got=%h ok=%b exp=aa", d, ok); end
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL len0_done got=%b exp=1", done); end
        @(negedge clk);
        checks++; if (srdy_cnt != sr0) begin failures++; $display("FAIL len0_src_ready high_cycles=%0d exp=0", srdy_cnt - sr0); end
        checks++; if (done_cnt - dn0 != 1) begin failures++; $display("FAIL len0_done_count got=%0d exp=1", done_cnt - dn0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL len0_busy got=%b exp=0", busy); end
    endtask

    task automatic test_stall();
        logic [7:0] d;
        int s, dn0, n, tx_bad, busy_bad;
        bit ok;
        dn0 = done_cnt;
        tx_bad = 0;
        busy_bad = 0;
        start = 1'b1;
        len = 16'd1;
        @(negedge clk);
        start = 1'b0;
        capture_frame(d, s, ok);
        capture_frame(d, s, ok);
        checks++; if (!ok || d !== 8'hAA) begin failures++; $display("FAIL stall_frameAA got=%h ok=%b exp=aa", d, ok); end
        repeat (500) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_bad++;
            if (busy !== 1'b1) busy_bad++;
        end
        checks++; if (tx_bad != 0) begin failures++; $display("FAIL stall_tx low_cycles=%0d exp=0", tx_bad); end
        checks++; if (busy_bad != 0) begin failures++; $display("FAIL stall_busy low_cycles=%0d exp=0", busy_bad); end
        checks++; if (done_cnt != dn0) begin failures++; $display("FAIL stall_no_done got=%0d exp=0", done_cnt - dn0); end
        src_valid = 1'b1;
        src_data = 8'hC3;
        capture_frame(d, s, ok);
        src_valid = 1'b0;
        checks++; if (!ok || d !== 8'hC3) begin failures++; $display("FAIL stall_resume got=%h ok=%b exp=c3", d, ok); end
        n = 0;
        while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int dn0, tx_bad;
        dn0 = done_cnt;
        tx_bad = 0;
        start = 1'b1;
        len = 16'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (43) @(negedge clk);
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL rstmid_bit4 got=%b exp=0", tx); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (src_ready !== 1'b0) begin failures++; $display("FAIL rstmid_src_ready got=%b exp=0", src_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rstmid_tx_ready got=%b exp=1", tx_ready); end
        repeat (200) begin
            if (tx !== 1'b1) tx_bad++;
            @(negedge clk);
        end
        checks++; if (tx_bad != 0) begin failures++; $display("FAIL rstmid_quiet low_cycles=%0d exp=0", tx_bad); end
        checks++; if (done_cnt != dn0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt - dn0); end
    endtask

    task automatic test_ignore_in_gap();
        logic [7:0] d;
        int s55, saa, s, hs0, dn0, n;
        bit ok;
        hs0 = hs_cnt;
        dn0 = done_cnt;
        start = 1'b1;
        len = 16'd1;
        @(negedge clk);
        start = 1'b0;
        capture_frame(d, s55, ok);
        repeat (10) @(negedge clk);
        start = 1'b1;
        len = 16'd3;
        wr = 1'b1;
        tx_data = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wr = 1'b0;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL gapign_tx got=%b exp=1", tx); end
        capture_frame(d, saa, ok);
        checks++; if (!ok || d !== 8'hAA) begin failures++; $display("FAIL gapign_frameAA got=%h ok=%b exp=aa", d, ok); end
        checks++; if (saa - s55 - 100 != 1152) begin failures++; $display("FAIL gapign_gap got=%0d exp=1152", saa - s55 - 100); end
        src_valid = 1'b1;
        src_data = 8'h5A;
        capture_frame(d, s, ok);
        checks++; if (!ok || d !== 8'h5A) begin failures++; $display("FAIL gapign_frame5A got=%h ok=%b exp=5a", d, ok); end
        n = 0;
        while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        src_valid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL gapign_done got=%b exp=1", done); end
        @(negedge clk);
        checks++; if (hs_cnt - hs0 != 1) begin failures++; $display("FAIL gapign_handshakes got=%0d exp=1", hs_cnt - hs0); end
        checks++; if (done_cnt - dn0 != 1) begin failures++; $display("FAIL gapign_done_count got=%0d exp=1", done_cnt - dn0); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        wr = 1'b0;
        src_valid = 1'b0;
        len = '0;
        src_data = '0;
        tx_data = '0;
        @(negedge clk);
        test_reset();
        test_wr_passthrough();
        test_sequence();
        test_len_zero();
        test_stall();
        test_reset_midframe();
        test_ignore_in_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_prog_sender.md
UART_PROG_SENDER -- requirements
Module: uart_prog_sender

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 27000000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: line rate; BIT_CYC = CLOCK_HZ/BAUD (integer division).
REQ-003 SHALL have parameter GAP_US, default 1000: idle time between 0x55 and 0xAA; GAP_CYC = CLOCK_HZ*GAP_US/1000000; legal range 200..19000.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle request to send a program-load sequence.
REQ-007 SHALL have port len  in  16  program byte count; sampled when start is accepted.
REQ-008 SHALL have port busy  out  1  high while a sequence is in progress.
REQ-009 SHALL have port done  out  1  one-cycle pulse when a sequence completes.
REQ-010 SHALL have port src_data  in  8  program byte.
REQ-011 SHALL have port src_valid  in  1  src_data is valid.
REQ-012 SHALL have port src_ready  out  1  block takes src_data in this cycle if src_valid.
REQ-013 SHALL have port wr  in  1  pass-through write strobe for tx_data.
REQ-014 SHALL have port tx_data  in  8  pass-through byte.
REQ-015 SHALL have port tx_ready  out  1  pass-through write is accepted this cycle.
REQ-016 SHALL have port tx  out  1  serial line, 8N1, LSB first, idle high.

Function
REQ-017 SHALL contain one byte serializer: on load, tx goes low (start bit) the next cycle; start, 8 data bits, stop bit each held BIT_CYC cycles; serializer is idle again after 10*BIT_CYC cycles.
REQ-018 SHALL implement sequencer states IDLE, SEND55, GAP, SENDAA, STREAM, FIN.
REQ-019 SHALL drive tx_ready = 1 only in IDLE with serializer idle; wr && tx_ready loads tx_data into the serializer.
REQ-020 SHALL accept start only in IDLE with serializer idle; on accept, latch len, set busy the next cycle, enter SEND55.
REQ-021 SHALL, if start and wr are both high in an accepting cycle, accept start and discard the wr byte.
REQ-022 SHALL ignore start and wr while busy or while the serializer is active.
REQ-023 SEND55: SHALL load 0x55; when its stop bit completes, enter GAP.
REQ-024 GAP: SHALL hold tx high for exactly GAP_CYC cycles, then enter SENDAA.
REQ-025 SENDAA: SHALL load 0xAA; when its frame completes, enter STREAM (or FIN if latched len = 0).
REQ-026 STREAM: SHALL drive src_ready = 1 only when the serializer is idle and the remaining count > 0; src_valid && src_ready loads src_data and decrements the count.
REQ-027 SHALL keep tx high with no timeout while src_valid is low in STREAM.
REQ-028 SHALL enter FIN when the count reaches 0 and the last frame completes; FIN pulses done for one cycle and returns to IDLE; busy is low in the cycle after done.
REQ-029 SHALL keep src_ready = 0 outside STREAM, and tx_ready = 0 whenever busy.
REQ-030 SHALL support len up to 65535 with no count wrap-around; the count is 16 bits and stops at 0.

Reset
REQ-031 SHALL, with rst high at a clock edge, force tx = 1, busy = 0, done = 0, src_ready = 0, state IDLE, serializer idle, counters 0, including mid-frame and mid-gap.
REQ-032 SHALL drive tx_ready = 1 in the first cycle after rst is released.

Verification (CLOCK_HZ=1152000, BAUD=115200 -> BIT_CYC=10; GAP_US=1000 -> GAP_CYC=1152)
REQ-033 SHALL check: wr with tx_data=0x61 in IDLE -> tx bits 0,1,0,0,0,0,1,1,0,1, each 10 cycles; tx_ready low for 100 cycles.
REQ-034 SHALL check: start, len=2, src bytes 0x12, 0x34 -> frame 0x55, 1152 cycles high, frame 0xAA, frames 0x12, 0x34; exactly 2 src handshakes; one done pulse.
REQ-035 SHALL check: start, len=0 -> frame 0x55, gap, frame 0xAA, done; src_ready never high.
REQ-036 SHALL check: src_valid held low 500 cycles in STREAM -> tx high, busy 1, no done; the sequence resumes when src_valid rises.
REQ-037 SHALL check: rst pulse during bit 4 of 0x55 -> tx = 1 and busy = 0 in the next cycle; tx_ready = 1 after release.
REQ-038 SHALL check: start and wr pulsed during GAP -> no effect on tx, len, or the sequence.
